// File: rtl/key_latch_bank.sv
// Debounced key bank with per-key latches and a FWFT event queue of press indices.
// Presses flag a pending bit; the lowest pending key drains into the queue each cycle.
module key_latch_bank #(
  parameter int N_KEYS          = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int TOGGLE_MODE     = 0,
  localparam int KW = $clog2(N_KEYS),
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] keys,
  input  logic              clear,
  output logic [N_KEYS-1:0] latched,
  output logic              evt_valid,
  output logic [KW-1:0]     evt_key,
  input  logic              evt_ready,
  output logic [CW-1:0]     evt_count,
  output logic              overflow
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] db;
  logic [7:0]        cnt [N_KEYS];
  logic [N_KEYS-1:0] pending;
  logic [KW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;

  logic [N_KEYS-1:0] flip;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] push_sel;
  logic [KW-1:0]     push_key;
  logic              push_hit;
  logic              full;
  logic              push;
  logic              pop;

  // Handshake: an entry leaves the queue on a rising edge where evt_valid && evt_ready
  // are both high; evt_key is the oldest entry and is stable while evt_valid is high.
  assign evt_valid = (evt_count != '0);
  assign evt_key   = evt_valid ? mem[rptr] : '0;
  assign full      = (evt_count == CW'(FIFO_DEPTH));
  assign pop       = evt_valid && evt_ready;
  assign push      = push_hit && (!full || pop);

  always_comb begin
    flip  = '0;
    press = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if ((keys[i] != db[i]) && (cnt[i] == CNT_LAST)) begin
        flip[i]  = 1'b1;
        press[i] = ~db[i];
      end
    end
  end

  // Lowest-index pending key wins the single push slot.
  always_comb begin
    push_hit = 1'b0;
    push_key = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        push_hit = 1'b1;
        push_key = KW'(i);
      end
    end
    push_sel = '0;
    if (push) push_sel[push_key] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db        <= '0;
      latched   <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      evt_count <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
    end else begin
      // Debounce keeps running through clear so a held key is not seen as a new press.
      for (int i = 0; i < N_KEYS; i++) begin
        if (keys[i] == db[i] || flip[i]) cnt[i] <= '0;
        else                             cnt[i] <= cnt[i] + 8'd1;
        if (flip[i]) db[i] <= ~db[i];
      end
      if (clear) begin
        latched   <= '0;
        pending   <= '0;
        overflow  <= 1'b0;
        wptr      <= '0;
        rptr      <= '0;
        evt_count <= '0;
      end else begin
        if (TOGGLE_MODE != 0) latched <= latched ^ press;
        else                  latched <= latched | press;
        pending <= (pending & ~push_sel) | press;
        if ((press & pending & ~push_sel) != '0) overflow <= 1'b1;
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        case ({push, pop})
          2'b10:   evt_count <= evt_count + CW'(1);
          2'b01:   evt_count <= evt_count - CW'(1);
          default: evt_count <= evt_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !clear && push) mem[wptr] <= push_key;
  end

endmodule

// File: doc/key_latch_bank.md
KEY_LATCH_BANK -- requirements
Module: key_latch_bank

Interface
REQ-001 SHALL have parameter N_KEYS, default 10, number of key channels (2..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive differing samples needed to accept a change (1..255).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event queue entries (power of two, 2..64).
REQ-004 SHALL have parameter TOGGLE_MODE, default 0: 0 = sticky set, 1 = each press inverts the latch.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port keys  input  N_KEYS  raw key levels, 1 = pressed.
REQ-008 SHALL have port clear  input  1  synchronous clear of latches, queue, pending and overflow.
REQ-009 SHALL have port latched  output  N_KEYS  per-key latch state.
REQ-010 SHALL have port evt_valid  output  1  queue head valid.
REQ-011 SHALL have port evt_key  output  $clog2(N_KEYS)  key index at queue head.
REQ-012 SHALL have port evt_ready  input  1  consumer accepts head.
REQ-013 SHALL have port evt_count  output  $clog2(FIFO_DEPTH+1)  queue occupancy.
REQ-014 SHALL have port overflow  output  1  sticky lost-event flag.

Function
REQ-015 Each channel SHALL hold a debounced state db[i] and counter; counter clears on any edge where keys[i]==db[i], increments otherwise.
REQ-016 db[i] SHALL flip on the DEBOUNCE_CYCLES-th consecutive edge with keys[i]!=db[i]; counter clears on that edge.
REQ-017 A press SHALL be a 0->1 flip of db[i]; releases generate nothing.
REQ-018 On a press, latched[i] SHALL update on the same edge db[i] flips: set to 1 (TOGGLE_MODE=0) or inverted (TOGGLE_MODE=1).
REQ-019 On a press, pending[i] SHALL be set on the same edge.
REQ-020 Each edge, the lowest-index set pending bit SHALL be pushed into the queue and cleared, if the queue is not full or a pop occurs on that edge; at most one push per edge.
REQ-021 Latency: latched rises DEBOUNCE_CYCLES edges after keys rises; evt_valid rises one edge later when queue was empty.
REQ-022 Queue SHALL be first-word-fall-through: evt_valid = (evt_count!=0); evt_key = oldest entry.
REQ-023 Pop SHALL occur on an edge where evt_valid && evt_ready; evt_ready with empty queue is ignored.
REQ-024 Simultaneous push and pop SHALL leave evt_count unchanged, including when full.
REQ-025 Full queue with no pop SHALL stall: pending bits retained, nothing dropped.
REQ-026 A press on a channel whose pending bit is already set SHALL set overflow; pending stays 1 (one event recorded, the other lost).
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 clear SHALL on the next edge zero latched, pending, overflow and evt_count; debounce state and counters retained, so a held key does not re-press.
REQ-029 clear SHALL win over same-edge press, push and pop; that press is discarded (no latch, no event).

Reset
REQ-030 reset_n low at an edge SHALL zero db, counters, latched, pending, queue pointers, evt_count, overflow; evt_valid=0, evt_key=0.
REQ-031 Reset SHALL override clear and all other inputs, including mid-debounce and mid-drain.
REQ-032 Outputs SHALL remain at reset values while reset_n is low; after release a key already held high is pressed after DEBOUNCE_CYCLES edges.

Verification (defaults: N_KEYS=10, DEBOUNCE_CYCLES=4, FIFO_DEPTH=8)
REQ-033 keys[3]=1 held 6 cycles, evt_ready=0 -> latched=0x008 at 4th edge; evt_valid=1, evt_key=3, evt_count=1 at 5th edge.
REQ-034 keys[5]=1 for 3 cycles then 0 -> latched=0x000, evt_count=0 throughout.
REQ-035 keys=0x155 in one cycle, held, evt_ready=1 -> latched=0x155 (341); events 0,2,4,6,8 on consecutive cycles; evt_count returns to 0.
REQ-036 TOGGLE_MODE=1: press/release/press key 1 -> latched[1] goes 1 then 0; two events with key 1.
REQ-037 evt_ready=0: press keys 0..7 (count=8), press key 9 (pending), release, re-press key 9 -> evt_count=8, overflow=1; then evt_ready=1 -> 0..7 then 9 drained.
REQ-038 keys[2] held and latched, clear=1 one cycle -> latched=0, evt_count=0, overflow=0, no re-latch; then reset_n=0 one edge mid-debounce of key 4 -> all outputs 0, key 4 needs 4 fresh edges after release.
